// File: rtl/mapper_gen.sv
// mapper_gen: translates 16-bit CPU addresses to PHYS_AW-bit physical addresses using MAP offsets/enables.
// Define MAPPER_NMI_MASK_EN to gate NMI through the same MAP..EOM window as IRQ.
module mapper_gen #(
    parameter int         NUM_OFFSETS = 2,
    parameter int         PHYS_AW     = 20,
    parameter logic [7:0] MAP_OPCODE  = 8'h5C,
    parameter logic [7:0] EOM_OPCODE  = 8'hEA,
    localparam int NUM_BYTES   = 2 * NUM_OFFSETS,
    localparam int SEL_W       = ($clog2(NUM_BYTES) > 1) ? $clog2(NUM_BYTES) : 1,
    localparam int NUM_REGIONS = 4 * NUM_OFFSETS,
    localparam int RW          = $clog2(NUM_REGIONS),
    localparam int GW          = $clog2(NUM_OFFSETS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    input  logic               sync,
    input  logic [7:0]         data_i,
    input  logic [7:0]         data_o,
    input  logic               ext_irq,
    input  logic               ext_nmi,
    output logic               cpu_irq,
    output logic               cpu_nmi,
    input  logic               map_enable_ext,
    input  logic [SEL_W-1:0]   map_reg_sel,
    output logic [7:0]         map_reg,
    input  logic [7:0]         map_reg_hyper,
    input  logic               load_map_hyper,
    input  logic [15:0]        core_address_next,
    output logic [PHYS_AW-1:0] address_next,
    output logic [PHYS_AW-1:0] address,
    output logic               map_next,
    output logic               map,
    output logic               map_busy
);
    // Offsets hold physical address bits [PHYS_AW-1:8]; HW of them live in the odd byte.
    localparam int OW  = PHYS_AW - 8;
    localparam int HW  = PHYS_AW - 16;
    localparam int GSW = (GW > 0) ? GW : 1;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic                 seq_we;
    logic [OW-1:0]        offset_q [NUM_OFFSETS];
    logic [NUM_REGIONS-1:0] enable_q;
    logic                 int_enable;
    logic [NUM_BYTES-1:0] byte_we;
    logic [7:0]           byte_wd [NUM_BYTES];
    logic [7:0]           byte_rd [NUM_BYTES];
    logic                 map_start, eom_seen, disable_i;
    logic [RW-1:0]        region;
    logic [GSW-1:0]       group;
    logic                 en;
    logic [OW-1:0]        sum;

    assign map_start = (data_i == MAP_OPCODE) && sync && ready;
    assign eom_seen  = (data_i == EOM_OPCODE) && sync && ready;
    assign disable_i = (state_q == S_LOAD) && (idx_q == '0);
    assign map_busy  = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (map_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                // The current byte is reloaded every cycle; only ready advances.
                seq_we = 1'b1;
                if (ready) begin
                    if (idx_q == SEL_W'(NUM_BYTES - 1)) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer data overrides a hypervisor write aimed at the same byte.
    always_comb begin
        for (int k = 0; k < NUM_BYTES; k++) begin
            byte_we[k] = 1'b0;
            byte_wd[k] = map_reg_hyper;
            if (load_map_hyper && (int'(map_reg_sel) == k)) byte_we[k] = 1'b1;
            if (seq_we && (int'(idx_q) == k)) begin
                byte_we[k] = 1'b1;
                byte_wd[k] = data_o;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < NUM_OFFSETS; g++) offset_q[g] <= '0;
            enable_q <= '0;
        end else begin
            for (int g = 0; g < NUM_OFFSETS; g++) begin
                if (byte_we[2*g]) offset_q[g][7:0] <= byte_wd[2*g];
                if (byte_we[2*g+1]) begin
                    offset_q[g][OW-1:8] <= byte_wd[2*g+1][HW-1:0];
                    enable_q[4*g +: 4]  <= byte_wd[2*g+1][7:4];
                end
            end
        end
    end

    always_comb begin
        map_reg = 8'h00;
        for (int g = 0; g < NUM_OFFSETS; g++) begin
            byte_rd[2*g]   = offset_q[g][7:0];
            byte_rd[2*g+1] = {enable_q[4*g +: 4], 4'(offset_q[g][OW-1:8])};
        end
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (int'(map_reg_sel) == k) map_reg = byte_rd[k];
        end
    end

    assign region = core_address_next[15 -: RW];
    generate
        if (GW > 0) begin : g_group
            assign group = core_address_next[15 -: GSW];
        end else begin : g_group_single
            assign group = '0;
        end
    endgenerate

    // Offset is added in 256-byte pages; the carry out of the top bit is dropped.
    assign en  = enable_q[region] & map_enable_ext;
    assign sum = (en ? offset_q[group] : '0) + OW'(core_address_next[15:8]);

    assign address_next = ready ? {sum, core_address_next[7:0]} : address;
    assign map_next     = ready ? en : map;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address <= '0;
            map     <= 1'b0;
        end else if (ready) begin
            address <= address_next;
            map     <= map_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          int_enable <= 1'b1;
        else if (disable_i) int_enable <= 1'b0;
        else if (eom_seen)  int_enable <= 1'b1;
    end

    assign cpu_irq = ext_irq & int_enable;
`ifdef MAPPER_NMI_MASK_EN
    assign cpu_nmi = ext_nmi & int_enable;
`else
    assign cpu_nmi = ext_nmi;
`endif

endmodule

// File: tb/tb_mapper_gen.sv
// Bench for mapper_gen: default instance plus a NUM_OFFSETS=4/PHYS_AW=18 instance, both checked
// every cycle against a page-arithmetic model, with literal expectations from hand calculation.
module tb_mapper_gen;
    logic        clk = 1'b0;
    logic        reset, ready, sync, ext_irq, ext_nmi, map_enable_ext, load_map_hyper;
    logic [7:0]  data_i, data_o, map_reg_hyper;
    logic [2:0]  sel;
    logic [15:0] core_address_next;

    logic [7:0]  map_reg_0, map_reg_1;
    logic [19:0] address_next_0, address_0;
    logic [17:0] address_next_1, address_1;
    logic        cpu_irq_0, cpu_nmi_0, map_next_0, map_0, map_busy_0;
    logic        cpu_irq_1, cpu_nmi_1, map_next_1, map_1, map_busy_1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mapper_gen dut0 (
        .clk(clk), .reset(reset), .ready(ready), .sync(sync), .data_i(data_i), .data_o(data_o),
        .ext_irq(ext_irq), .ext_nmi(ext_nmi), .cpu_irq(cpu_irq_0), .cpu_nmi(cpu_nmi_0),
        .map_enable_ext(map_enable_ext), .map_reg_sel(sel[1:0]), .map_reg(map_reg_0),
        .map_reg_hyper(map_reg_hyper), .load_map_hyper(load_map_hyper),
        .core_address_next(core_address_next), .address_next(address_next_0), .address(address_0),
        .map_next(map_next_0), .map(map_0), .map_busy(map_busy_0)
    );

    mapper_gen #(.NUM_OFFSETS(4), .PHYS_AW(18)) dut1 (
        .clk(clk), .reset(reset), .ready(ready), .sync(sync), .data_i(data_i), .data_o(data_o),
        .ext_irq(ext_irq), .ext_nmi(ext_nmi), .cpu_irq(cpu_irq_1), .cpu_nmi(cpu_nmi_1),
        .map_enable_ext(map_enable_ext), .map_reg_sel(sel), .map_reg(map_reg_1),
        .map_reg_hyper(map_reg_hyper), .load_map_hyper(load_map_hyper),
        .core_address_next(core_address_next), .address_next(address_next_1), .address(address_1),
        .map_next(map_next_1), .map(map_1), .map_busy(map_busy_1)
    );

    // ---------------- behavioural model ----------------
    int         nof [2] = '{2, 4};
    int         paw [2] = '{20, 18};
    int         m_pos [2];          // -1 when idle, else index of the byte being loaded
    logic [7:0] m_b [2][8];         // register bytes as they read back
    bit         m_ie [2];
    int         m_addr [2];
    bit         m_map [2];

    function automatic logic [7:0] mask_of(input int i, input int k);
        if (k % 2 == 0) return 8'hFF;
        return 8'hF0 | 8'((1 << (paw[i] - 16)) - 1);
    endfunction

    function automatic bit en_of(input int i, input int a);
        int r;
        r = a / (65536 / (4 * nof[i]));
        return m_b[i][2 * (r / 4) + 1][4 + r % 4] && map_enable_ext;
    endfunction

    function automatic int phys_of(input int i, input int a);
        int g, off;
        g   = a / (65536 / nof[i]);
        off = (m_b[i][2*g+1] & 8'h0F) * 256 + m_b[i][2*g];
        return ((en_of(i, a) ? off * 256 : 0) + a) % (1 << paw[i]);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_pos[i]  <= -1;
                m_ie[i]   <= 1'b1;
                m_addr[i] <= 0;
                m_map[i]  <= 1'b0;
                for (int k = 0; k < 8; k++) m_b[i][k] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int a, hs;
                a  = int'(core_address_next);
                hs = (i == 0) ? int'(sel) % 4 : int'(sel);
                if (ready) begin
                    m_addr[i] <= phys_of(i, a);
                    m_map[i]  <= en_of(i, a);
                end
                if (m_pos[i] == 0) m_ie[i] <= 1'b0;
                else if (data_i == 8'hEA && sync && ready) m_ie[i] <= 1'b1;
                if (load_map_hyper) m_b[i][hs] <= map_reg_hyper & mask_of(i, hs);
                // later assignment wins: sequencer beats hypervisor on the same byte
                if (m_pos[i] >= 0) begin
                    m_b[i][m_pos[i]] <= data_o & mask_of(i, m_pos[i]);
                    if (ready) m_pos[i] <= (m_pos[i] + 1 == 2 * nof[i]) ? -1 : m_pos[i] + 1;
                end else if (data_i == 8'h5C && sync && ready) begin
                    m_pos[i] <= 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_inst(input int i, input logic [31:0] an, input logic [31:0] aq,
                            input logic mn, input logic mq, input logic busy,
                            input logic [7:0] mr, input logic irq, input logic nmi);
        int a, s;
        a = int'(core_address_next);
        s = (i == 0) ? int'(sel) % 4 : int'(sel);
        chk($sformatf("d%0d address_next", i), an, ready ? phys_of(i, a) : m_addr[i]);
        chk($sformatf("d%0d map_next", i), {31'd0, mn}, ready ? {31'd0, en_of(i, a)} : {31'd0, m_map[i]});
        chk($sformatf("d%0d address", i), aq, m_addr[i]);
        chk($sformatf("d%0d map", i), {31'd0, mq}, {31'd0, m_map[i]});
        chk($sformatf("d%0d map_busy", i), {31'd0, busy}, {31'd0, m_pos[i] >= 0});
        chk($sformatf("d%0d map_reg", i), {24'd0, mr}, {24'd0, m_b[i][s]});
        chk($sformatf("d%0d cpu_irq", i), {31'd0, irq}, {31'd0, ext_irq & m_ie[i]});
`ifdef MAPPER_NMI_MASK_EN
        chk($sformatf("d%0d cpu_nmi", i), {31'd0, nmi}, {31'd0, ext_nmi & m_ie[i]});
`else
        chk($sformatf("d%0d cpu_nmi", i), {31'd0, nmi}, {31'd0, ext_nmi});
`endif
    endtask

    always @(negedge clk) begin
        chk_inst(0, 32'(address_next_0), 32'(address_0), map_next_0, map_0, map_busy_0,
                 map_reg_0, cpu_irq_0, cpu_nmi_0);
        chk_inst(1, 32'(address_next_1), 32'(address_1), map_next_1, map_1, map_busy_1,
                 map_reg_1, cpu_irq_1, cpu_nmi_1);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ready = 1'b1; sync = 1'b0; data_i = 8'h00; data_o = 8'h00;
        ext_irq = 1'b1; ext_nmi = 1'b1; map_enable_ext = 1'b1; load_map_hyper = 1'b0;
        sel = 3'd1; map_reg_hyper = 8'h00; core_address_next = 16'h0000;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset address", 32'(address_0), 32'h0);
        chk("reset map_busy", {31'd0, map_busy_0}, 32'd0);
        chk("reset cpu_irq", {31'd0, cpu_irq_0}, 32'd1);

        // MAP sequence with a three-cycle stall in LOAD1
        data_i = 8'h5C; sync = 1'b1; tick();
        data_i = 8'h00; sync = 1'b0;
        chk("busy in LOAD0", {31'd0, map_busy_0}, 32'd1);
        data_o = 8'h12; tick();
        chk("irq gated after LOAD0", {31'd0, cpu_irq_0}, 32'd0);
        ready = 1'b0;
        data_o = 8'h77; tick(); data_o = 8'h55; tick(); data_o = 8'h66; tick();
        chk("busy during stall", {31'd0, map_busy_0}, 32'd1);
        chk("byte1 reload in stall", {24'd0, map_reg_0}, 32'h66);
        ready = 1'b1;
        data_o = 8'h31; tick(); data_o = 8'h40; tick(); data_o = 8'hF8; tick();
        chk("d0 idle after 4 bytes", {31'd0, map_busy_0}, 32'd0);
        chk("d1 still loading", {31'd0, map_busy_1}, 32'd1);
        data_o = 8'h00;

        core_address_next = 16'h2345; #1;
        chk("an 2345", 32'(address_next_0), 32'h13545);
        chk("mn 2345", {31'd0, map_next_0}, 32'd1);
        chk("model pin 2345", 32'(phys_of(0, 'h2345)), 32'h13545);
        tick();
        chk("registered 2345", 32'(address_0), 32'h13545);
        core_address_next = 16'hA0FF; #1;
        chk("an A0FF", 32'(address_next_0), 32'h8E0FF);
        chk("mn A0FF", {31'd0, map_next_0}, 32'd1);
        tick();
        core_address_next = 16'h6000; #1;
        chk("an 6000", 32'(address_next_0), 32'h06000);
        chk("mn 6000", {31'd0, map_next_0}, 32'd0);
        tick();
        tick();
        chk("d1 idle after 8 bytes", {31'd0, map_busy_1}, 32'd0);
`ifdef MAPPER_NMI_MASK_EN
        chk("nmi gated", {31'd0, cpu_nmi_0}, 32'd0);
`else
        chk("nmi passes", {31'd0, cpu_nmi_0}, 32'd1);
`endif

        // EOM re-enables interrupts
        data_i = 8'hEA; sync = 1'b1; tick();
        data_i = 8'h00; sync = 1'b0;
        chk("irq after EOM d0", {31'd0, cpu_irq_0}, 32'd1);
        chk("irq after EOM d1", {31'd0, cpu_irq_1}, 32'd1);

        // hypervisor port on the wide instance
        load_map_hyper = 1'b1; sel = 3'd6; map_reg_hyper = 8'h80; tick();
        sel = 3'd7; map_reg_hyper = 8'hF3; tick();
        load_map_hyper = 1'b0;
        chk("d1 readback byte7", {24'd0, map_reg_1}, 32'hF3);
        core_address_next = 16'hF010; #1;
        chk("d1 an F010", 32'(address_next_1), 32'h07010);
        chk("d1 mn F010", {31'd0, map_next_1}, 32'd1);
        map_enable_ext = 1'b0; #1;
        chk("d1 an F010 disabled", 32'(address_next_1), 32'h0F010);
        chk("d1 mn F010 disabled", {31'd0, map_next_1}, 32'd0);
        map_enable_ext = 1'b1;
        load_map_hyper = 1'b1; map_reg_hyper = 8'hFF; tick();
        load_map_hyper = 1'b0;
        chk("d1 byte7 masked", {24'd0, map_reg_1}, 32'hF3);

        // page wrap on the default instance
        load_map_hyper = 1'b1; sel = 3'd0; map_reg_hyper = 8'hFF; tick();
        sel = 3'd1; map_reg_hyper = 8'h1F; tick();
        load_map_hyper = 1'b0;
        core_address_next = 16'h1234; #1;
        chk("wrap an", 32'(address_next_0), 32'h01134);
        chk("model pin wrap", 32'(phys_of(0, 'h1234)), 32'h01134);
        tick();

        // write collisions, then asynchronous reset in LOAD2
        data_i = 8'h5C; sync = 1'b1; tick();
        data_i = 8'h00; sync = 1'b0;
        data_o = 8'hAB; load_map_hyper = 1'b1; sel = 3'd0; map_reg_hyper = 8'hCD; tick();
        data_o = 8'h11; sel = 3'd2; map_reg_hyper = 8'h5A; tick();
        load_map_hyper = 1'b0;
        chk("hyper other byte", {24'd0, map_reg_0}, 32'h5A);
        sel = 3'd0; #1;
        chk("sequencer wins", {24'd0, map_reg_0}, 32'hAB);
        chk("irq gated before reset", {31'd0, cpu_irq_0}, 32'd0);
        reset = 1'b1; #1;
        chk("async reset busy d0", {31'd0, map_busy_0}, 32'd0);
        chk("async reset busy d1", {31'd0, map_busy_1}, 32'd0);
        chk("async reset map_reg", {24'd0, map_reg_0}, 32'h00);
        chk("async reset irq", {31'd0, cpu_irq_0}, {31'd0, ext_irq});
        tick();
        reset = 1'b0;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            sync  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       data_i = 8'h5C;
                1:       data_i = 8'hEA;
                default: data_i = 8'($urandom_range(0, 255));
            endcase
            data_o            = 8'($urandom_range(0, 255));
            ext_irq           = 1'($urandom_range(0, 1));
            ext_nmi           = 1'($urandom_range(0, 1));
            map_enable_ext    = ($urandom_range(0, 4) != 0);
            load_map_hyper    = ($urandom_range(0, 4) == 0);
            sel               = 3'($urandom_range(0, 7));
            map_reg_hyper     = 8'($urandom_range(0, 255));
            core_address_next = 16'($urandom_range(0, 65535));
            reset             = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
